// File: rtl/apu_pkg.sv
// Shared widths, FSM encoding and output clamp for the APU voice mixer.
package apu_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int ACC_W      = 18;
  localparam int PERIOD_W   = 32;
  localparam int NUM_VOICES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } mix_state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -18'sd32768;

  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX) begin
      return SAT_MAX[SAMPLE_W-1:0];
    end else if (a < SAT_MIN) begin
      return SAT_MIN[SAMPLE_W-1:0];
    end
    return a[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/voice_osc.sv
// One square-wave voice: registered period, free-running phase counter and
// level comparator. Periods below 2 mute the voice.
module voice_osc
  import apu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  output logic                level,
  output logic                active
);

  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] ph_reg;

  assign active = (period_reg >= PERIOD_W'(2));
  assign level  = (ph_reg < (period_reg >> 1));

  // A new period restarts the phase so the first half-cycle is always full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_reg <= '0;
      ph_reg     <= '0;
    end else if (period != period_reg) begin
      period_reg <= period;
      ph_reg     <= '0;
    end else if (!active || (ph_reg == period_reg - PERIOD_W'(1))) begin
      ph_reg <= '0;
    end else begin
      ph_reg <= ph_reg + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// Four-voice square synthesiser: on each request, sums the voices one per
// cycle into a wide accumulator and presents a clamped 16-bit sample.
module voice_mixer
  import apu_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] AMPLITUDE = 16'sd6000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period0,
  input  logic [PERIOD_W-1:0] period1,
  input  logic [PERIOD_W-1:0] period2,
  input  logic [PERIOD_W-1:0] period3,
  input  logic                sample_req,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                busy
);

  localparam logic signed [ACC_W-1:0] AMP_EXT = ACC_W'(AMPLITUDE);

  logic [PERIOD_W-1:0]   period_arr [NUM_VOICES];
  logic [NUM_VOICES-1:0] level_vec;
  logic [NUM_VOICES-1:0] active_vec;

  assign period_arr[0] = period0;
  assign period_arr[1] = period1;
  assign period_arr[2] = period2;
  assign period_arr[3] = period3;

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      voice_osc u_osc (
        .clk    (clk),
        .reset  (reset),
        .period (period_arr[gi]),
        .level  (level_vec[gi]),
        .active (active_vec[gi])
      );
    end
  endgenerate

  mix_state_t                 state_reg, state_next;
  logic [1:0]                 idx_reg, idx_next;
  logic signed [ACC_W-1:0]    acc_reg, acc_next;
  logic signed [SAMPLE_W-1:0] sample_reg, sample_next;
  logic                       valid_reg, valid_next;
  logic signed [ACC_W-1:0]    contrib;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      acc_reg    <= '0;
      sample_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      acc_reg    <= acc_next;
      sample_reg <= sample_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    acc_next    = acc_reg;
    sample_next = sample_reg;
    valid_next  = 1'b0;
    contrib     = '0;

    if (active_vec[idx_reg]) begin
      contrib = level_vec[idx_reg] ? AMP_EXT : -AMP_EXT;
    end

    case (state_reg)
      IDLE: begin
        if (sample_req) begin
          acc_next   = '0;
          idx_next   = '0;
          state_next = ACC;
        end
      end
      ACC: begin
        acc_next = acc_reg + contrib;
        idx_next = idx_reg + 2'd1;
        // The output registers load on entry to DONE so the new sample and
        // its strobe are both visible for the whole DONE cycle.
        if (idx_reg == 2'd3) begin
          state_next  = DONE;
          sample_next = saturate(acc_next);
          valid_next  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sample       = sample_reg;
  assign sample_valid = valid_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer: two instances (default and loud
// amplitude) share stimulus and are checked against a phase-history model.
module tb_voice_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] per_in [4];
  logic        sample_req = 1'b0;

  logic [15:0] sample_a, sample_b;
  logic        valid_a, valid_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  voice_mixer dut_a (
    .clk          (clk),
    .reset        (reset),
    .period0      (per_in[0]),
    .period1      (per_in[1]),
    .period2      (per_in[2]),
    .period3      (per_in[3]),
    .sample_req   (sample_req),
    .sample       (sample_a),
    .sample_valid (valid_a),
    .busy         (busy_a)
  );

  voice_mixer #(.AMPLITUDE(16'sd10000)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .period0      (per_in[0]),
    .period1      (per_in[1]),
    .period2      (per_in[2]),
    .period3      (per_in[3]),
    .sample_req   (sample_req),
    .sample       (sample_b),
    .sample_valid (valid_b),
    .busy         (busy_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Model: each voice's history of (first cycle with ph=0, period) segments.
  typedef struct {
    int v;
    int start;
    int per;
  } seg_t;
  seg_t hist[$];
  int   reg_per [4];
  int   acc_q[$];
  int   busy_from = 0;
  int   busy_until = -1;
  int   model_sample [2];

  function automatic int contrib(int v, int t, int amp);
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k].v == v && hist[k].start <= t) begin
        int ph;
        if (hist[k].per < 2) return 0;
        ph = (t - hist[k].start) % hist[k].per;
        return (ph < hist[k].per / 2) ? amp : -amp;
      end
    end
    return 0;
  endfunction

  function automatic int mix(int n, int amp);
    int s = 0;
    for (int i = 0; i < 4; i++) s += contrib(i, n + 1 + i, amp);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the pending request when its strobe is due.
  always @(negedge clk) begin
    bit ev;
    bit eb;
    ev = (acc_q.size() > 0) && (acc_q[0] + 5 == cyc);
    eb = (cyc >= busy_from) && (cyc <= busy_until);
    if (ev) begin
      model_sample[0] = mix(acc_q[0], 6000);
      model_sample[1] = mix(acc_q[0], 10000);
      $display("txn req@%0d valid@%0d: sample_a=%0d (exp %0d) sample_b=%0d (exp %0d)",
               acc_q[0], cyc, $signed(sample_a), model_sample[0],
               $signed(sample_b), model_sample[1]);
      void'(acc_q.pop_front());
    end
    check("valid_a", int'(valid_a), int'(ev));
    check("valid_b", int'(valid_b), int'(ev));
    check("busy_a", int'(busy_a), int'(eb));
    check("busy_b", int'(busy_b), int'(eb));
    check("sample_a", int'($signed(sample_a)), model_sample[0]);
    check("sample_b", int'($signed(sample_b)), model_sample[1]);
  end

  task automatic step();
    @(posedge clk);
    #1;
    sample_req = 1'b0;
  endtask

  task automatic set_period(int v, int p);
    per_in[v] = p;
    if (p != reg_per[v]) begin
      hist.push_back('{v, cyc + 1, p});
      reg_per[v] = p;
    end
  endtask

  task automatic req();
    sample_req = 1'b1;
    if (cyc > busy_until) begin
      acc_q.push_back(cyc);
      busy_from  = cyc + 1;
      busy_until = cyc + 5;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    for (int v = 0; v < 4; v++) begin
      hist.push_back('{v, cyc, 0});
      reg_per[v] = 0;
    end
    acc_q.delete();
    busy_from  = 0;
    busy_until = -1;
    model_sample[0] = 0;
    model_sample[1] = 0;
    #2;
    reset = 1'b1;
    for (int v = 0; v < 4; v++) begin
      if (int'(per_in[v]) != 0) begin
        hist.push_back('{v, cyc + 1, int'(per_in[v])});
        reg_per[v] = int'(per_in[v]);
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && cyc <= busy_until; i++) step();
  endtask

  task automatic wait_phase(int k, int m, int target);
    for (int i = 0; i < 40; i++) begin
      if (cyc > busy_until && ((cyc - k) % m) == target) break;
      step();
    end
  endtask

  int k, k3;

  initial begin
    for (int v = 0; v < 4; v++) begin
      per_in[v]  = '0;
      reg_per[v] = 0;
      hist.push_back('{v, 0, 0});
    end
    model_sample[0] = 0;
    model_sample[1] = 0;

    // Reset, then all voices muted.
    repeat (3) step();
    reset = 1'b1;
    step();
    req();
    repeat (8) step();

    // Single voice, period 8: sampled at ph 2, then ph 6.
    k = cyc;
    set_period(0, 8);
    wait_phase(k, 8, 2);
    req();
    step();
    wait_phase(k, 8, 6);
    req();
    step();
    // Period change with the old phase in its low half: restart makes it high.
    wait_phase(k, 8, 4);
    set_period(0, 4);
    req();
    step();
    wait_idle();
    req();
    step();

    // All four voices high, then all low.
    wait_idle();
    k3 = cyc;
    for (int v = 0; v < 4; v++) set_period(v, 8);
    req();
    step();
    wait_phase(k3, 8, 4);
    req();
    step();

    // Reset in the second ACC cycle discards the request.
    wait_idle();
    req();
    step();
    step();
    pulse_reset();
    repeat (10) step();

    // Back-to-back requests: only every sixth cycle is accepted.
    wait_idle();
    repeat (12) begin
      req();
      step();
    end
    repeat (6) step();

    // Random periods and requests.
    repeat (400) begin
      for (int v = 0; v < 4; v++) begin
        if ($urandom % 10 == 0) set_period(v, int'($urandom_range(12, 0)));
      end
      if ($urandom % 4 == 0) req();
      step();
    end
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
